// File: rtl/dcache_store_buf_pkg.sv
// dcache_pkg: shared types and helpers for the D-cache store buffer.
//   ST_BYTE/ST_HALF/ST_WORD : store type codes (also the unshifted lane mask)
//   sb_state_e              : drain FSM states
//   sb_entry_t              : one buffered store {addr, data, mask}
//   LINE_OFF_W              : byte-offset width of the default 64-byte line
// The entry address width is fixed here by SB_ADDR_W. Modules that carry
// ADDR_W must keep it equal to SB_ADDR_W.
package dcache_pkg;

  localparam logic [3:0] ST_BYTE = 4'b0001;
  localparam logic [3:0] ST_HALF = 4'b0011;
  localparam logic [3:0] ST_WORD = 4'b1111;

  localparam int SB_ADDR_W      = 32;
  localparam int LINE_BYTES_DEF = 64;
  localparam int LINE_OFF_W     = $clog2(LINE_BYTES_DEF);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    MISS_WAIT = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           mask;
  } sb_entry_t;

  // Unknown type codes are treated as misaligned so that they are rejected.
  function automatic logic st_aligned(input logic [3:0] st_type, input logic [1:0] a);
    case (st_type)
      ST_BYTE: st_aligned = 1'b1;
      ST_HALF: st_aligned = ~a[0];
      ST_WORD: st_aligned = (a == 2'b00);
      default: st_aligned = 1'b0;
    endcase
  endfunction

  // Copy right-aligned data into every lane so that the lane mask alone
  // selects the bytes to be written.
  function automatic logic [31:0] st_replicate(input logic [3:0] st_type, input logic [31:0] d);
    case (st_type)
      ST_BYTE: st_replicate = {4{d[7:0]}};
      ST_HALF: st_replicate = {2{d[15:0]}};
      default: st_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/dcache_store_buf_if.sv
// dcache_store_buf_if: LSU store port, cache request/refill port and SRAM
// write port of the store buffer.
//   master : LSU + cache side (drives stores, grant/miss, refill)
//   slave  : the store buffer
interface dcache_store_buf_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 4
);
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_W-1:0]     st_addr;
  logic [31:0]           st_data;
  logic [3:0]            st_type;
  logic                  st_misalign;
  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  wr_grant;
  logic                  wr_miss;
  logic                  refill_valid;
  logic [LINE_BITS-1:0]  refill_data;
  logic [LINE_BITS-1:0]  mem_din;
  logic [LINE_BYTES-1:0] mem_we;
  logic                  buf_empty;
  logic [CNT_W-1:0]      buf_cnt;

  modport master (
    output st_valid, st_addr, st_data, st_type, wr_grant, wr_miss, refill_valid, refill_data,
    input  st_ready, st_misalign, wr_req, wr_addr, mem_din, mem_we, buf_empty, buf_cnt
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_type, wr_grant, wr_miss, refill_valid, refill_data,
    output st_ready, st_misalign, wr_req, wr_addr, mem_din, mem_we, buf_empty, buf_cnt
  );
endinterface

// File: rtl/dcache_store_buf_line_we_gen.sv
// line_we_gen: places one 32-bit store word into a cache line.
//   wr_en       : a write happens this cycle (otherwise mem_we = 0)
//   merge       : overlay onto refill_data and write the whole line
//   word_idx    : word position within the line
//   mask, data  : lane mask and lane-replicated store data
//   refill_data : refill line (used only when merge = 1)
//   mem_din     : line write data
//   mem_we      : per-byte write enables
module line_we_gen #(
  parameter int LINE_BYTES = 64,
  parameter int IDX_W      = 4
) (
  input  logic                    wr_en,
  input  logic                    merge,
  input  logic [IDX_W-1:0]        word_idx,
  input  logic [3:0]              mask,
  input  logic [31:0]             data,
  input  logic [8*LINE_BYTES-1:0] refill_data,
  output logic [8*LINE_BYTES-1:0] mem_din,
  output logic [LINE_BYTES-1:0]   mem_we
);

  always_comb begin
    mem_din = '0;
    mem_we  = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wr_en) begin
        if (merge) begin
          mem_we[b] = 1'b1;
          mem_din[8*b +: 8] = (((b / 4) == int'(word_idx)) && mask[b % 4])
                              ? data[8*(b % 4) +: 8] : refill_data[8*b +: 8];
        end else begin
          mem_we[b] = ((b / 4) == int'(word_idx)) && mask[b % 4];
          mem_din[8*b +: 8] = data[8*(b % 4) +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_store_buf.sv
// dcache_store_buf: in-order store FIFO that drains into the D-cache data SRAM.
// A hit writes the head word's bytes; a miss waits for the refill line, overlays
// the head store and writes the full line.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dcache_store_buf_if.slave (store port, cache port, SRAM write port)
// Optional: DCACHE_STORE_COALESCE_EN merges an aligned store into the youngest
// entry when both target the same word.
//
// state     | meaning
// IDLE      | buffer empty, no request
// REQ       | head entry presented to the cache (wr_req=1)
// MISS_WAIT | head missed, waiting for the refill line
module dcache_store_buf
  import dcache_pkg::*;
#(
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = SB_ADDR_W
) (
  input logic             clk,
  input logic             rst,
  dcache_store_buf_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_state_e        state_q, state_d;
  sb_entry_t        fifo_q [DEPTH];
  sb_entry_t        head, new_ent;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             full, aligned, st_fire, push_alloc, push_merge, pop, misalign_q;
  logic [IDX_W-1:0] word_idx;

  assign head           = fifo_q[rd_ptr_q];
  assign full           = (cnt_q == CNT_W'(DEPTH));
  assign aligned        = st_aligned(bus.st_type, bus.st_addr[1:0]);
  assign new_ent.addr   = SB_ADDR_W'(bus.st_addr);
  assign new_ent.data   = st_replicate(bus.st_type, bus.st_data);
  assign new_ent.mask   = bus.st_type << bus.st_addr[1:0];

  assign pop = ((state_q == REQ) && bus.wr_grant) ||
               ((state_q == MISS_WAIT) && bus.refill_valid);

`ifdef DCACHE_STORE_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
  sb_entry_t        young, merged;
  logic             can_merge;

  assign young_ptr = wr_ptr_q - 1'b1;
  assign young     = fifo_q[young_ptr];
  // A single entry is also the head: it must not change while it is being
  // written or while its refill merge is pending.
  assign can_merge = aligned && (cnt_q != '0) &&
                     (young.addr[ADDR_W-1:2] == bus.st_addr[ADDR_W-1:2]) &&
                     !((cnt_q == CNT_W'(1)) && (pop || (state_q == MISS_WAIT)));
  assign bus.st_ready = !full || can_merge;
  assign push_merge   = st_fire && can_merge;

  always_comb begin
    merged      = young;
    merged.mask = young.mask | new_ent.mask;
    for (int i = 0; i < 4; i++) begin
      if (new_ent.mask[i]) merged.data[8*i +: 8] = new_ent.data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (push_alloc)      fifo_q[wr_ptr_q]  <= new_ent;
    else if (push_merge) fifo_q[young_ptr] <= merged;
  end
`else
  assign bus.st_ready = !full;
  assign push_merge   = 1'b0;

  always_ff @(posedge clk) begin
    if (push_alloc) fifo_q[wr_ptr_q] <= new_ent;
  end
`endif

  assign st_fire    = bus.st_valid && bus.st_ready;
  assign push_alloc = st_fire && aligned && !push_merge;
  assign cnt_nxt    = cnt_q + CNT_W'(push_alloc) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_nxt;
      misalign_q <= st_fire && !aligned;
      if (push_alloc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cnt_nxt != '0) state_d = REQ;
      REQ: begin
        if (bus.wr_grant)     state_d = (cnt_nxt != '0) ? REQ : IDLE;
        else if (bus.wr_miss) state_d = MISS_WAIT;
      end
      MISS_WAIT: if (bus.refill_valid) state_d = (cnt_nxt != '0) ? REQ : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign bus.wr_req      = (state_q == REQ);
  assign bus.wr_addr     = head.addr[ADDR_W-1:0];
  assign bus.st_misalign = misalign_q;
  assign bus.buf_empty   = (cnt_q == '0);
  assign bus.buf_cnt     = cnt_q;

  if (OFF_W > 2) begin : g_idx
    assign word_idx = head.addr[OFF_W-1:2];
  end else begin : g_idx0
    assign word_idx = '0;
  end

  line_we_gen #(
    .LINE_BYTES(LINE_BYTES),
    .IDX_W     (IDX_W)
  ) u_line_we_gen (
    .wr_en      (pop),
    .merge      (state_q == MISS_WAIT),
    .word_idx   (word_idx),
    .mask       (head.mask),
    .data       (head.data),
    .refill_data(bus.refill_data),
    .mem_din    (bus.mem_din),
    .mem_we     (bus.mem_we)
  );

endmodule

// File: tb/tb_dcache_store_buf.sv
// tb_dcache_store_buf: scoreboard bench for dcache_store_buf (64-byte line,
// 4 entries). Expected SRAM writes are queued when stimulus is driven and
// compared in order whenever mem_we is non-zero.
module tb_dcache_store_buf;
  import dcache_pkg::*;

  localparam int LB    = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_store_buf_if #(.ADDR_W(AW), .LINE_BYTES(LB), .DEPTH(DEPTH)) bus ();

  dcache_store_buf #(.LINE_BYTES(LB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [LB-1:0]   we;
    logic [8*LB-1:0] din;
    logic [AW-1:0]   addr;
    logic            chk_addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] exp_we(input logic [31:0] a, input logic [3:0] t);
    logic [3:0] m;
    m = t << a[1:0];
    return LB'(m) << (4 * a[5:2]);
  endfunction

  function automatic logic [31:0] exp_word(input logic [3:0] t, input logic [31:0] d);
    case (t)
      4'b0001: return {4{d[7:0]}};
      4'b0011: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic sb_hit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    sb_q.push_back('{we: exp_we(a, t), din: {16{exp_word(t, d)}}, addr: a, chk_addr: 1'b1});
  endtask

  // Called at posedge+1; returns at posedge+1 after the store was accepted.
  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    int n = 0;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_type  = t;
    #1;
    while (!bus.st_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready_bound", 32'(n < 20), 1);
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
  endtask

  task automatic grant(input int n);
    bus.wr_grant = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.wr_grant = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mem_we != '0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", bus.mem_we, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mem_we", bus.mem_we, mon_e.we);
        chk("mem_din", bus.mem_din, mon_e.din);
        if (mon_e.chk_addr) chk("wr_addr", bus.wr_addr, mon_e.addr);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [3:0]  t;
  } mis_t;

  initial begin
    logic [8*LB-1:0] line;
    mis_t mis_tab[3];

    rst              = 1'b1;
    bus.st_valid     = 1'b0;
    bus.st_addr      = '0;
    bus.st_data      = '0;
    bus.st_type      = '0;
    bus.wr_grant     = 1'b0;
    bus.wr_miss      = 1'b0;
    bus.refill_valid = 1'b0;
    bus.refill_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_buf_empty", bus.buf_empty, 1);
    chk("rst_buf_cnt", bus.buf_cnt, 0);
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_misalign", bus.st_misalign, 0);

    // byte store, hit next cycle
    sb_q.push_back('{we: 64'h8, din: {64{8'hAB}}, addr: 32'h1003, chk_addr: 1'b1});
    push_st(32'h1003, 32'h0000_00AB, ST_BYTE);
    chk("t1_wr_req_latency", bus.wr_req, 1);
    chk("t1_buf_cnt", bus.buf_cnt, 1);
    grant(1);
    chk("t1_buf_empty", bus.buf_empty, 1);
    chk("t1_wr_req_idle", bus.wr_req, 0);

    // word store at the last word of the line
    sb_q.push_back('{we: 64'hF000_0000_0000_0000, din: {16{32'h1234_5678}},
                     addr: 32'h103C, chk_addr: 1'b1});
    push_st(32'h103C, 32'h1234_5678, ST_WORD);
    grant(1);
    chk("t2_buf_empty", bus.buf_empty, 1);

    // misaligned / illegal stores are rejected with a one-cycle pulse
    mis_tab[0] = '{a: 32'h2001, t: ST_HALF};
    mis_tab[1] = '{a: 32'h2002, t: ST_WORD};
    mis_tab[2] = '{a: 32'h2000, t: 4'b0101};
    for (int i = 0; i < 3; i++) begin
      push_st(mis_tab[i].a, 32'h1234, mis_tab[i].t);
      chk("t3_misalign_pulse", bus.st_misalign, 1);
      chk("t3_buf_cnt", bus.buf_cnt, 0);
      chk("t3_wr_req", bus.wr_req, 0);
      @(posedge clk); #1;
      chk("t3_misalign_clear", bus.st_misalign, 0);
      chk("t3_wr_req_after", bus.wr_req, 0);
    end

    // fill to DEPTH, fifth store waits for a slot
    for (int i = 0; i < 4; i++) begin
      sb_hit(32'h5000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), ST_WORD);
      push_st(32'h5000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), ST_WORD);
    end
    chk("t4_buf_cnt_full", bus.buf_cnt, 4);
    chk("t4_st_ready_full", bus.st_ready, 0);
    sb_hit(32'h5010, 32'hA0A0_0004, ST_WORD);
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h5010;
    bus.st_data  = 32'hA0A0_0004;
    bus.st_type  = ST_WORD;
    bus.wr_grant = 1'b1;
    #1;
    chk("t4_ready_during_pop", bus.st_ready, 0);
    @(posedge clk); #1;
    bus.wr_grant = 1'b0;
    chk("t4_ready_after_pop", bus.st_ready, 1);
    chk("t4_buf_cnt_3", bus.buf_cnt, 3);
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    chk("t4_buf_cnt_refill", bus.buf_cnt, 4);
    grant(4);
    chk("t4_drained", bus.buf_empty, 1);
    chk("t4_wr_req_idle", bus.wr_req, 0);

    // miss, then refill merge
    push_st(32'h3008, 32'hDEAD_BEEF, ST_WORD);
    bus.wr_miss = 1'b1;
    @(posedge clk); #1;
    bus.wr_miss = 1'b0;
    chk("t5_wr_req_miss", bus.wr_req, 0);
    chk("t5_mem_we_wait", bus.mem_we, 0);
    chk("t5_buf_cnt", bus.buf_cnt, 1);
    @(posedge clk); #1;
    chk("t5_still_waiting", bus.wr_req, 0);
    line = {64{8'h11}};
    line[95:64] = 32'hDEAD_BEEF;
    sb_q.push_back('{we: {LB{1'b1}}, din: line, addr: 32'h3008, chk_addr: 1'b0});
    bus.refill_valid = 1'b1;
    bus.refill_data  = {64{8'h11}};
    @(posedge clk); #1;
    bus.refill_valid = 1'b0;
    chk("t5_buf_empty", bus.buf_empty, 1);
    chk("t5_wr_req_idle", bus.wr_req, 0);

    // grant wins over a simultaneous miss
    sb_hit(32'h6002, 32'h5A, ST_BYTE);
    push_st(32'h6002, 32'h5A, ST_BYTE);
    bus.wr_grant = 1'b1;
    bus.wr_miss  = 1'b1;
    @(posedge clk); #1;
    bus.wr_grant = 1'b0;
    bus.wr_miss  = 1'b0;
    chk("t6_buf_empty", bus.buf_empty, 1);
    sb_hit(32'h6004, 32'h0BAD_F00D, ST_WORD);
    push_st(32'h6004, 32'h0BAD_F00D, ST_WORD);
    chk("t6_not_miss_wait", bus.wr_req, 1);
    grant(1);
    chk("t6_drained", bus.buf_empty, 1);

    // reset while a miss is pending discards it
    push_st(32'h7000, 32'hCAFE_F00D, ST_WORD);
    bus.wr_miss = 1'b1;
    @(posedge clk); #1;
    bus.wr_miss = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t7_buf_cnt", bus.buf_cnt, 0);
    chk("t7_buf_empty", bus.buf_empty, 1);
    chk("t7_wr_req", bus.wr_req, 0);
    bus.refill_valid = 1'b1;
    bus.refill_data  = {64{8'h22}};
    #1;
    chk("t7_no_refill_write", bus.mem_we, 0);
    @(posedge clk); #1;
    bus.refill_valid = 1'b0;

    // two bytes in the same word, no grant in between
`ifdef DCACHE_STORE_COALESCE_EN
    sb_q.push_back('{we: 64'h3, din: {16{32'h0101_0201}}, addr: 32'h4000, chk_addr: 1'b1});
`else
    sb_hit(32'h4000, 32'h01, ST_BYTE);
    sb_hit(32'h4001, 32'h02, ST_BYTE);
`endif
    push_st(32'h4000, 32'h01, ST_BYTE);
    push_st(32'h4001, 32'h02, ST_BYTE);
`ifdef DCACHE_STORE_COALESCE_EN
    chk("t8_buf_cnt_merged", bus.buf_cnt, 1);
`else
    chk("t8_buf_cnt_split", bus.buf_cnt, 2);
`endif
    grant(2);
    chk("t8_drained", bus.buf_empty, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_store_buf.md
Name: dcache_store_buf

Overview:
- Parametrised store buffer and line-write generator between the LSU store stage and the D-cache data SRAM.
- Accepts byte/half/word stores into a DEPTH-entry FIFO and converts each entry to per-byte line write-data and write-enables.
- Drains the head entry on a cache hit; on a miss, waits for the refill line, overlays the head store and writes the whole merged line.
- Adds misalignment rejection and refill merging.

Parameters:
LINE_BYTES, 64, bytes per cache line (power of 2, >=4); LINE_BITS = 8*LINE_BYTES
DEPTH, 4, store entries (power of 2, >=2)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request
st_ready  out  1  buffer can accept (not full)
st_addr  in  ADDR_W  byte address
st_data  in  32  store data, right-aligned
st_type  in  4  0001 byte, 0011 half, 1111 word
st_misalign  out  1  one-cycle pulse: store rejected
wr_req  out  1  head entry requests the cache
wr_addr  out  ADDR_W  head entry address
wr_grant  in  1  tag hit, SRAM port granted this cycle
wr_miss  in  1  tag miss for head this cycle
refill_valid  in  1  refill line present (one cycle)
refill_data  in  LINE_BITS  refill line
mem_din  out  LINE_BITS  SRAM write data
mem_we  out  LINE_BYTES  per-byte write enable
buf_empty  out  1  no entries
buf_cnt  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset: FIFO empty; state IDLE; wr_req, st_misalign, mem_we, mem_din all 0; st_ready=1; buf_empty=1; buf_cnt=0.
- Reset mid-operation discards all entries, including a pending miss.
- Enqueue when st_valid && st_ready.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or any other type code.
  - A misaligned store is not enqueued; st_misalign=1 next cycle.
  - Entry stores: addr; 4-bit lane mask = type << addr[1:0]; data replicated to 32 bits (byte x4, half x2).
- st_ready = !full. A pop in the same cycle does not free a slot for that cycle's push.
- States:
  - IDLE: buffer empty; wr_req=0. Go to REQ when count>0.
  - REQ: wr_req=1; wr_addr = head addr.
    - wr_grant: mem_din = head word replicated across the line; mem_we = lane mask << (4*addr[log2(LINE_BYTES)-1:2]); head popped. Stay in REQ if more entries remain, else go to IDLE.
    - wr_miss (grant has priority if both are high): go to MISS_WAIT.
  - MISS_WAIT: wr_req=0. On refill_valid, in the same cycle: mem_din = refill_data with head's enabled bytes overwritten; mem_we = all ones; head popped. Next state as in REQ after a grant.
- mem_din and mem_we are combinational from head registers and state. mem_we=0 when no write occurs; mem_din is don't-care.
- Latency:
  - Push at cycle t makes wr_req=1 at t+1 when the buffer was empty.
  - Back-to-back grants drain one entry per cycle.
- Entries are never reordered. Only the head is merged on refill; younger same-line stores hit later.
- Pointers wrap mod DEPTH.
- buf_cnt changes by push minus pop each cycle: simultaneous push and pop leaves it unchanged.

Optional Feature:
- Macro: DCACHE_STORE_COALESCE_EN.
- Defined:
  - An aligned push whose word address matches the youngest entry merges into it: mask OR, new bytes override old. No slot is allocated and buf_cnt is unchanged.
  - Merging is allowed when the buffer is full.
  - Merging is blocked if the youngest entry is the head and is being popped or is in MISS_WAIT.
- Undefined: every accepted store allocates an entry.

Decomposition:
- Package dcache_pkg:
  - store type encodings BYTE/HALF/WORD;
  - state enum IDLE/REQ/MISS_WAIT;
  - entry struct {addr, data[31:0], mask[3:0]};
  - LINE_OFF_W = log2(LINE_BYTES).
- Sub-module line_we_gen: combinational word-to-line lane placement (mask shift, data replication, refill overlay), reused by the I-cache path.

Test Plan:
- Byte store addr 0x1003, data 0xAB, grant next cycle -> mem_we = bit 3 only; mem_din[31:24] = 0xAB; buf_empty=1 after.
- Word store addr 0x103C (LINE_BYTES=64) -> mem_we bits 63:60 set; mem_din[511:480] = st_data.
- Half store addr 0x2001 -> st_misalign pulse; buf_cnt stays 0; wr_req stays 0.
- Five stores, DEPTH=4, no grant -> st_ready=0 after the fourth store. The fifth is held until the first grant, then accepted the following cycle.
- Word 0xDEADBEEF at 0x3008, wr_miss, then refill of all 0x11 bytes -> mem_we = all ones; line bytes 8..11 = EF,BE,AD,DE; all other bytes 0x11.
- With DCACHE_STORE_COALESCE_EN: bytes to 0x4000 and 0x4001 with no grant -> buf_cnt=1; on grant, mem_we bits 1:0 set.
